bin_2_bcd_seq: RTL and testbench
================================

Name: bin_2_bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Converts any WIDTH-bit unsigned value, not only 0..9, into DIGITS packed BCD digits.
- Uses valid/ready handshakes on input and output, so it sits between a binary datapath and display/UART formatting logic.
- Spends one iteration cycle per input bit to keep area small.

Parameters:
- WIDTH, default 8: binary input width; legal range 1..32.
- DIGITS, default 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1. An undersized DIGITS is an illegal configuration and its behaviour is undefined.

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- in_valid  input  1: in_data is valid.
- in_ready  output  1: converter can accept a value.
- in_data  input  WIDTH: unsigned binary operand.
- out_valid  output  1: out_bcd holds a finished result.
- out_ready  input  1: downstream accepts the result.
- out_bcd  output  4*DIGITS: packed BCD. Bits [3:0] are the units digit; the most significant digit is in the top nibble.
- busy  output  1: high while in SHIFT.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE, out_valid = 0, out_bcd = 0, busy = 0, internal shift register = 0, bit counter = 0. in_ready is 1 while rst_n is held low and immediately after release.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready:
    - load the binary shift register with in_data;
    - clear the BCD accumulator;
    - set counter = WIDTH;
    - go to SHIFT.
  - SHIFT: in_ready = 0, busy = 1. Each cycle:
    - every accumulator nibble >= 5 gets +3 (carry confined to that nibble);
    - then {accumulator, binary} shift left by 1; the binary MSB enters the accumulator LSB;
    - counter decrements.
    - When counter reaches 0 after the step, go to DONE.
  - DONE: out_valid = 1, in_ready = 0. On out_ready, go to IDLE and drop out_valid on the next cycle.
- Latency: if the input is accepted in cycle k, out_valid is high from cycle k+WIDTH+1.
- Throughput: at most one conversion per WIDTH+2 cycles. There is no overlap: the next input is accepted no earlier than the cycle after the output handshake.
- out_bcd:
  - driven from a register that updates only on the SHIFT to DONE transition;
  - holds its last value in IDLE and in SHIFT;
  - remains stable while out_valid & !out_ready, with no glitch or change under backpressure.
- in_data is sampled only on the acceptance edge; changes to it during SHIFT have no effect.
- Boundaries:
  - in_data = 0 gives all-zero digits.
  - in_data = 2^WIDTH - 1 gives the exact maximum decimal value with no truncation for a legal DIGITS.
  - Unused upper digits are 0; no leading-digit blanking is applied.
- in_valid asserted during SHIFT or DONE: ignored and not queued. The upstream must hold in_valid until in_ready.
- out_ready asserted outside DONE: no effect.
- Reset mid-operation: any state returns to IDLE immediately and the partial result is discarded. out_valid falls to 0 asynchronously and out_bcd clears to 0.
- No X outputs in any reachable state.

Optional Feature:
- Macro: BIN2BCD_GRAY_OUT_EN.
- When defined:
  - adds output port out_gray, WIDTH bits;
  - out_gray = in_data ^ (in_data >> 1), registered on the acceptance edge;
  - it is presented alongside out_bcd, qualified by the same out_valid/out_ready, and held under backpressure;
  - reset value is 0.
- When undefined: the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Max value, defaults: WIDTH=8, DIGITS=3, in_data=255 accepted in cycle k, out_ready=1. out_valid rises in cycle k+9 with out_bcd=12'h255; out_valid low again the cycle after.
- Zero and small values, defaults: in_data=0 gives 12'h000; in_data=9 gives 12'h009; in_data=100 gives 12'h100. Verify in_ready=0 throughout SHIFT/DONE and in_ready=1 the cycle after each output handshake.
- Backpressure: in_data=173 converted, out_ready held 0 for 5 cycles. out_valid stays 1 and out_bcd stays 12'h173 unchanged; a new in_valid during the hold is not accepted.
- Reset mid-conversion: rst_n pulsed low during the 4th SHIFT cycle. Asynchronously out_valid=0, busy=0, out_bcd=0; after release, in_ready=1 and a fresh in_data=42 gives 12'h042.
- Re-parametrised instance, WIDTH=4, DIGITS=2: in_data=15 gives 8'h15 after 5 cycles from acceptance; exhaustive 0..15 matches decimal.
- With BIN2BCD_GRAY_OUT_EN and defaults: in_data=8'b0000_0011 gives out_gray=8'b0000_0010 and out_bcd=12'h003 in the same out_valid cycle.

Source files
------------

// File: rtl/bin_2_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per input bit.
// Define BIN2BCD_GRAY_OUT_EN to add a registered Gray-code copy of the operand (out_gray).
module bin_2_bcd_seq #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
`ifdef BIN2BCD_GRAY_OUT_EN
   output logic [WIDTH-1:0]      out_gray,
`endif
   output logic                  busy
);

   localparam int unsigned BcdW = 4 * DIGITS;
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  bin_q, bin_d;
   logic [BcdW-1:0]   acc_q, acc_d;
   logic [BcdW-1:0]   bcd_q, bcd_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [BcdW-1:0]   acc_adj;
   logic [BcdW-1:0]   acc_shift;

   // Add-3 correction per nibble; the +3 never carries out of a nibble that was <= 9.
   always_comb begin
      acc_adj = acc_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
      acc_shift = {acc_adj[BcdW-2:0], bin_q[WIDTH-1]};
   end

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               bin_d   = in_data;
               acc_d   = '0;
               cnt_d   = CntW'(WIDTH);
               state_d = StShift;
            end
         end
         StShift: begin
            busy  = 1'b1;
            bin_d = bin_q << 1;
            acc_d = acc_shift;
            cnt_d = cnt_q - CntW'(1);
            // Result register only moves on the final step, so it is stable elsewhere.
            if (cnt_q == CntW'(1)) begin
               bcd_d   = acc_shift;
               state_d = StDone;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         bin_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
      end
   end

   assign out_bcd = bcd_q;

`ifdef BIN2BCD_GRAY_OUT_EN
   logic [WIDTH-1:0] gray_q, gray_d;

   always_comb begin
      gray_d = gray_q;
      if (state_q == StIdle && in_valid) begin
         gray_d = in_data ^ (in_data >> 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_q <= '0;
      end else begin
         gray_q <= gray_d;
      end
   end

   assign out_gray = gray_q;
`endif

endmodule

// File: tb/tb_bin_2_bcd_seq.sv
// Randomised self-checking bench for bin_2_bcd_seq: default 8-bit/3-digit instance
// plus a 4-bit/2-digit instance, checked against a divide-by-ten decimal model.
module tb_bin_2_bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [7:0]  in_data;
   logic [11:0] out_bcd;

   logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
   logic [3:0]  in_data4;
   logic [7:0]  out_bcd4;

`ifdef BIN2BCD_GRAY_OUT_EN
   logic [7:0]  out_gray;
   logic [3:0]  out_gray4;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [11:0] last_bcd  = '0;
   logic [7:0]  last_bcd4 = '0;

   always #5 clk = ~clk;

   bin_2_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
`ifdef BIN2BCD_GRAY_OUT_EN
      .out_gray  (out_gray),
`endif
      .busy      (busy)
   );

   bin_2_bcd_seq #(.WIDTH(4), .DIGITS(2)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .in_data   (in_data4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_bcd   (out_bcd4),
`ifdef BIN2BCD_GRAY_OUT_EN
      .out_gray  (out_gray4),
`endif
      .busy      (busy4)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   // Decimal digits by repeated division, packed units-first.
   function automatic logic [31:0] ref_bcd(input int unsigned v, input int unsigned digits);
      logic [31:0] r = '0;
      for (int unsigned i = 0; i < digits; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic convert8(input logic [7:0] v, input int hold);
      logic [11:0] exp = 12'(ref_bcd(v, 3));
      @(negedge clk);
      check_eq("idle_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = v;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      for (int i = 1; i <= 8; i++) begin
         if (i > 1) @(negedge clk);
         check_eq("shift_busy", busy, 1);
         check_eq("shift_in_ready", in_ready, 0);
         check_eq("shift_out_valid", out_valid, 0);
         check_eq("shift_bcd_hold", out_bcd, last_bcd);
      end
      @(negedge clk);
      check_eq("done_out_valid", out_valid, 1);
      check_eq("done_bcd", out_bcd, exp);
      check_eq("done_busy", busy, 0);
      check_eq("done_in_ready", in_ready, 0);
`ifdef BIN2BCD_GRAY_OUT_EN
      check_eq("done_gray", out_gray, v ^ (v >> 1));
`endif
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(negedge clk);
         check_eq("bp_out_valid", out_valid, 1);
         check_eq("bp_bcd", out_bcd, exp);
         check_eq("bp_in_ready", in_ready, 0);
         check_eq("bp_busy", busy, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("post_out_valid", out_valid, 0);
      check_eq("post_in_ready", in_ready, 1);
      check_eq("post_bcd_hold", out_bcd, exp);
      last_bcd = exp;
   endtask

   task automatic convert4(input logic [3:0] v);
      logic [7:0] exp = 8'(ref_bcd(v, 2));
      @(negedge clk);
      check_eq("w4_in_ready", in_ready4, 1);
      in_valid4 = 1'b1;
      in_data4  = v;
      @(negedge clk);
      in_valid4 = 1'b0;
      in_data4  = 4'($urandom);
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) @(negedge clk);
         check_eq("w4_shift_out_valid", out_valid4, 0);
         check_eq("w4_shift_bcd_hold", out_bcd4, last_bcd4);
      end
      @(negedge clk);
      check_eq("w4_out_valid", out_valid4, 1);
      check_eq("w4_bcd", out_bcd4, exp);
`ifdef BIN2BCD_GRAY_OUT_EN
      check_eq("w4_gray", out_gray4, v ^ (v >> 1));
`endif
      out_ready4 = 1'b1;
      @(negedge clk);
      out_ready4 = 1'b0;
      check_eq("w4_post_out_valid", out_valid4, 0);
      last_bcd4 = exp;
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      in_valid4  = 1'b0;
      in_data4   = '0;
      out_ready4 = 1'b0;
      #2;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_bcd", out_bcd, 0);
      check_eq("rst_in_ready", in_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      convert8(8'd255, 0);
      convert8(8'd0, 0);
      convert8(8'd9, 1);
      convert8(8'd100, 0);
      convert8(8'd3, 0);
      convert8(8'd173, 5);
      for (int n = 0; n < 30; n++) begin
         convert8(8'($urandom), int'($urandom_range(0, 3)));
      end

      // Abort during the 4th shift step; out_bcd is nonzero going in.
      convert8(8'd199, 0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd200;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("pre_rst_busy", busy, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("arst_out_valid", out_valid, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_bcd", out_bcd, 0);
      check_eq("arst_in_ready", in_ready, 1);
      last_bcd  = '0;
      last_bcd4 = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rel_in_ready", in_ready, 1);
      convert8(8'd42, 0);

      for (int v = 0; v < 16; v++) begin
         convert4(4'(v));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
